alarm_bank: RTL and testbench
=============================

Name: alarm_bank

Overview:
Parametrised multi-channel alarm engine for the digital clock: N independently programmable hh:mm alarms, each with its own ring/snooze state machine, ring timeout and missed flag.
Compares against the live hour/min/sec from the time counter.
Drives the buzzer directly with a gated square tone.
Sits beside the clock controller and replaces the single alarm flag plus separate buzzer stage.

Parameters:
N_ALARMS, 4, number of alarm channels (1..16).
SNOOZE_MIN, 5, snooze length in minutes (1..59).
RING_TIMEOUT_S, 60, seconds a channel rings before auto-stop (1..255).
TONE_HALF_CYC, 12500, clk cycles per half tone period (2 kHz at 50 MHz).
GATE_HALF_CYC, 12500000, clk cycles per half on/off gate period (0.25 s on / 0.25 s off at 50 MHz).
MAX_SNOOZE, 3, snoozes allowed per ring event; used only with ALARM_SNOOZE_LIMIT_EN.

Ports:
clk  in  1  system clock; all logic single-domain.
rst  in  1  reset, synchronous, active-high.
hour  in  5  current hour 0..23, synchronous to clk.
min  in  6  current minute 0..59.
sec  in  6  current second 0..59.
wr_en  in  1  one-cycle write strobe for channel config.
wr_idx  in  IW  channel index; IW = max(1, clog2(N_ALARMS)).
wr_hour  in  5  alarm hour.
wr_min  in  6  alarm minute.
wr_enable  in  1  channel armed.
snooze_pulse  in  1  one-cycle snooze request (debounced key pulse).
dismiss_pulse  in  1  one-cycle dismiss request (debounced key pulse).
ring_mask  out  N_ALARMS  bit i = channel i RINGING.
missed_mask  out  N_ALARMS  sticky: channel i timed out unacknowledged.
alarm_on  out  1  OR of ring_mask.
beep  out  1  buzzer drive.

Behaviour:
- Reset: all channel configs cleared (hour 0, min 0, disarmed); states IDLE; snooze targets 0; ring_mask, missed_mask, alarm_on, beep = 0; sec_q = 0.
- Minute event: registered sec_q; min_evt = (sec == 0) && (sec_q != 0).
  - Decisions are taken only on min_evt cycles; state updates at the next edge.
  - 1-cycle latency from min_evt to ring_mask.
- sec_evt = (sec != sec_q); drives ring timers.
- Per-channel FSM, states IDLE, RINGING, SNOOZED:
  - IDLE -> RINGING: armed && min_evt && {hour,min} == {cfg_hour,cfg_min}. Ring timer cleared.
  - RINGING -> IDLE: dismiss_pulse.
  - RINGING -> SNOOZED: snooze_pulse. Target computed as follows:
    - tgt_min = min + SNOOZE_MIN; if >= 60, subtract 60 and tgt_hour = hour + 1 (23 wraps to 0).
    - Computed from the live time on the snooze cycle.
  - RINGING -> IDLE: ring timer reaches RING_TIMEOUT_S sec_evts; missed_mask[i] set.
  - SNOOZED -> RINGING: min_evt && {hour,min} == target; timer cleared.
  - SNOOZED -> IDLE: dismiss_pulse.
- snooze_pulse and dismiss_pulse act on all applicable channels.
  - snooze_pulse affects RINGING channels only.
  - dismiss_pulse affects RINGING and SNOOZED channels.
- Write: wr_en loads config for channel wr_idx and forces that channel to IDLE.
  - The write also clears the channel's missed bit and snooze count.
  - An out-of-range wr_idx is ignored.
- Precedence per channel, highest first: rst > wr_en > dismiss > snooze > timeout > match.
  - Write and match in the same cycle: the channel goes IDLE; the new config is first compared at the next min_evt.
- A base-time match while RINGING or SNOOZED is ignored; no restart of the timer or target.
- Several channels matching the same minute all ring together.
- Disarming a channel by write stops it immediately.
- Beep path:
  - alarm_on = |ring_mask (registered).
  - Tone and gate counters are held at 0 with tone = gate = 1 while alarm_on = 0.
  - While alarm_on = 1: the tone counter toggles tone every TONE_HALF_CYC cycles; the gate counter toggles gate every GATE_HALF_CYC cycles.
  - beep is registered: beep = alarm_on & tone & gate. beep first rises 1 cycle after alarm_on and falls 1 cycle after alarm_on falls.

Optional Feature:
ALARM_SNOOZE_LIMIT_EN:
- Defined:
  - Each channel counts snoozes within one ring event; the count clears on dismiss, timeout, write, or IDLE->RINGING.
  - When the count equals MAX_SNOOZE, snooze_pulse on that channel acts as dismiss (-> IDLE, missed bit not set).
- Undefined: unlimited snoozes; MAX_SNOOZE and the counters are absent.

Test Plan:
Sim parameters for all scenarios: TONE_HALF_CYC=2, GATE_HALF_CYC=8, RING_TIMEOUT_S=3, SNOOZE_MIN=5.
1. Write ch0 = 07:30 armed; step time 07:29:59 -> 07:30:00 -> ring_mask=0001 one cycle after the sec=0 cycle; alarm_on=1; beep=1 on the next cycle, then pattern tone period 4, gated 8 on / 8 off.
2. Ch1 = 23:58 ringing; snooze_pulse at 23:58:10 -> ch1 SNOOZED, ring_mask=0; at 00:03:00 -> ring_mask=0010 again (hour wrap).
3. Ch2 ringing, no key; 3 sec_evts -> ring_mask[2]=0, missed_mask=0100; write ch2 -> missed_mask=0000.
4. Ch0 and ch3 both = 12:00 -> both bits set together (1001); dismiss_pulse and snooze_pulse in the same cycle -> both IDLE, not snoozed.
5. Ch0 ringing; wr_en ch0 = 12:00 disarmed in the same cycle as dismiss -> ring_mask=0, beep=0 within 2 cycles; rst asserted mid-ring -> all outputs 0 at the next edge.
6. With ALARM_SNOOZE_LIMIT_EN and MAX_SNOOZE=3: fourth snooze_pulse -> channel IDLE, missed bit 0; without the macro -> fourth snooze gives SNOOZED.

Source files
------------

// File: rtl/alarm_bank.sv
// alarm_bank: multi-channel hh:mm alarm engine with per-channel
// ring/snooze state machines, ring timeout, sticky missed flags and a
// gated square-tone buzzer drive.
//
// Optional build macro: ALARM_SNOOZE_LIMIT_EN
//   When defined, each channel allows at most MAX_SNOOZE snoozes per ring
//   event; the next snooze press acts as a dismiss. When undefined, snoozes
//   are unlimited and the snooze counters do not exist.
//
// Ports:
//   clk            system clock (single domain)
//   rst            synchronous active-high reset
//   hour/min/sec   live time from the time counter
//   wr_en          one-cycle channel config write strobe
//   wr_idx         channel to write (out-of-range values ignored)
//   wr_hour/min    alarm time for the written channel
//   wr_enable      armed flag for the written channel
//   snooze_pulse   snooze key pulse, applies to every RINGING channel
//   dismiss_pulse  dismiss key pulse, applies to RINGING and SNOOZED
//   ring_mask      bit i set while channel i is RINGING
//   missed_mask    sticky, channel i timed out without a key press
//   alarm_on       registered OR of ring_mask
//   beep           registered buzzer drive (tone gated on/off)
module alarm_bank #(
  parameter int N_ALARMS       = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int TONE_HALF_CYC  = 12500,
  parameter int GATE_HALF_CYC  = 12500000,
  parameter int MAX_SNOOZE     = 3,
  localparam int IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          hour,
  input  logic [5:0]          min,
  input  logic [5:0]          sec,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic [4:0]          wr_hour,
  input  logic [5:0]          wr_min,
  input  logic                wr_enable,
  input  logic                snooze_pulse,
  input  logic                dismiss_pulse,
  output logic [N_ALARMS-1:0] ring_mask,
  output logic [N_ALARMS-1:0] missed_mask,
  output logic                alarm_on,
  output logic                beep
);

  localparam int TCW = (TONE_HALF_CYC > 1) ? $clog2(TONE_HALF_CYC) : 1;
  localparam int GCW = (GATE_HALF_CYC > 1) ? $clog2(GATE_HALF_CYC) : 1;

  // Reject parameter values the channel logic cannot represent.
  if (N_ALARMS < 1 || N_ALARMS > 16 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59 ||
      RING_TIMEOUT_S < 1 || RING_TIMEOUT_S > 255 || TONE_HALF_CYC < 1 ||
      GATE_HALF_CYC < 1 || MAX_SNOOZE < 1) begin : gen_param_check
    $error("alarm_bank: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RINGING,
    ST_SNOOZED
  } state_t;

  // Time-base events
  logic [5:0] sec_q;
  logic       min_evt;
  logic       sec_evt;

  // Per-channel state
  state_t        state_q    [N_ALARMS];
  state_t        state_d    [N_ALARMS];
  logic [4:0]    cfg_hour_q [N_ALARMS];
  logic [4:0]    cfg_hour_d [N_ALARMS];
  logic [5:0]    cfg_min_q  [N_ALARMS];
  logic [5:0]    cfg_min_d  [N_ALARMS];
  logic [4:0]    tgt_hour_q [N_ALARMS];
  logic [4:0]    tgt_hour_d [N_ALARMS];
  logic [5:0]    tgt_min_q  [N_ALARMS];
  logic [5:0]    tgt_min_d  [N_ALARMS];
  logic [7:0]    timer_q    [N_ALARMS];
  logic [7:0]    timer_d    [N_ALARMS];
  logic [N_ALARMS-1:0] cfg_en_q, cfg_en_d;
  logic [N_ALARMS-1:0] missed_q, missed_d;
  logic [N_ALARMS-1:0] wr_hit, base_hit, tgt_hit, ring_d;

`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam int SCW = $clog2(MAX_SNOOZE + 1);
  logic [SCW-1:0] snz_cnt_q [N_ALARMS];
  logic [SCW-1:0] snz_cnt_d [N_ALARMS];
`endif

  // Snooze target, shared by all channels since it depends only on live time
  logic [6:0] snz_sum;
  logic [5:0] snz_min;
  logic [4:0] snz_hour;

  // Beep path
  logic [TCW-1:0] tone_cnt_q, tone_cnt_d;
  logic [GCW-1:0] gate_cnt_q, gate_cnt_d;
  logic           tone_q, tone_d;
  logic           gate_q, gate_d;
  logic           alarm_on_q, alarm_on_d;
  logic           beep_q, beep_d;

  // A minute boundary is the first cycle that sees sec back at zero.
  assign min_evt = (sec == 6'd0) && (sec_q != 6'd0);
  assign sec_evt = (sec != sec_q);

  // Snooze target from the live time; minute overflow carries into the hour.
  always_comb begin
    snz_sum  = {1'b0, min} + 7'(SNOOZE_MIN);
    snz_min  = snz_sum[5:0];
    snz_hour = hour;
    if (snz_sum >= 7'd60) begin
      snz_min  = 6'(snz_sum - 7'd60);
      snz_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    end
  end

  // Per-channel qualifiers: config write hit, base-time match, snooze-target match.
  always_comb begin
    wr_hit   = '0;
    base_hit = '0;
    tgt_hit  = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      wr_hit[i]   = wr_en && (wr_idx == IW'(i));
      base_hit[i] = cfg_en_q[i] && min_evt &&
                    (hour == cfg_hour_q[i]) && (min == cfg_min_q[i]);
      tgt_hit[i]  = min_evt && (hour == tgt_hour_q[i]) && (min == tgt_min_q[i]);
    end
  end

  // Channel next-state logic. The if/else order encodes the priority
  // write > dismiss > snooze > timeout > match, so a write in the same
  // cycle as a match leaves the channel idle.
  always_comb begin
    cfg_en_d = cfg_en_q;
    missed_d = missed_q;
    ring_d   = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      state_d[i]    = state_q[i];
      cfg_hour_d[i] = cfg_hour_q[i];
      cfg_min_d[i]  = cfg_min_q[i];
      tgt_hour_d[i] = tgt_hour_q[i];
      tgt_min_d[i]  = tgt_min_q[i];
      timer_d[i]    = timer_q[i];
`ifdef ALARM_SNOOZE_LIMIT_EN
      snz_cnt_d[i]  = snz_cnt_q[i];
`endif
      if (wr_hit[i]) begin
        cfg_hour_d[i] = wr_hour;
        cfg_min_d[i]  = wr_min;
        cfg_en_d[i]   = wr_enable;
        state_d[i]    = ST_IDLE;
        missed_d[i]   = 1'b0;
        timer_d[i]    = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
        snz_cnt_d[i]  = '0;
`endif
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (base_hit[i]) begin
              state_d[i] = ST_RINGING;
              timer_d[i] = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
              snz_cnt_d[i] = '0;
`endif
            end
          end
          ST_RINGING: begin
            if (dismiss_pulse) begin
              state_d[i] = ST_IDLE;
`ifdef ALARM_SNOOZE_LIMIT_EN
              snz_cnt_d[i] = '0;
`endif
            end else if (snooze_pulse) begin
`ifdef ALARM_SNOOZE_LIMIT_EN
              // Snooze budget used up: treat the press as a dismiss.
              if (snz_cnt_q[i] == SCW'(MAX_SNOOZE)) begin
                state_d[i]   = ST_IDLE;
                snz_cnt_d[i] = '0;
              end else begin
                state_d[i]    = ST_SNOOZED;
                tgt_hour_d[i] = snz_hour;
                tgt_min_d[i]  = snz_min;
                snz_cnt_d[i]  = snz_cnt_q[i] + 1'b1;
              end
`else
              state_d[i]    = ST_SNOOZED;
              tgt_hour_d[i] = snz_hour;
              tgt_min_d[i]  = snz_min;
`endif
            end else if (sec_evt) begin
              if (timer_q[i] == 8'(RING_TIMEOUT_S - 1)) begin
                state_d[i]  = ST_IDLE;
                missed_d[i] = 1'b1;
`ifdef ALARM_SNOOZE_LIMIT_EN
                snz_cnt_d[i] = '0;
`endif
              end else begin
                timer_d[i] = timer_q[i] + 8'd1;
              end
            end
          end
          ST_SNOOZED: begin
            if (dismiss_pulse) begin
              state_d[i] = ST_IDLE;
`ifdef ALARM_SNOOZE_LIMIT_EN
              snz_cnt_d[i] = '0;
`endif
            end else if (tgt_hit[i]) begin
              state_d[i] = ST_RINGING;
              timer_d[i] = '0;
            end
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
      ring_d[i] = (state_d[i] == ST_RINGING);
    end
  end

  // alarm_on is registered from the next-state ring bits so it lines up
  // with ring_mask; tone and gate run only while it is high.
  always_comb begin
    alarm_on_d = |ring_d;
    tone_cnt_d = tone_cnt_q;
    gate_cnt_d = gate_cnt_q;
    tone_d     = tone_q;
    gate_d     = gate_q;
    if (!alarm_on_q) begin
      tone_cnt_d = '0;
      gate_cnt_d = '0;
      tone_d     = 1'b1;
      gate_d     = 1'b1;
    end else begin
      if (tone_cnt_q == TCW'(TONE_HALF_CYC - 1)) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
      end
      if (gate_cnt_q == GCW'(GATE_HALF_CYC - 1)) begin
        gate_cnt_d = '0;
        gate_d     = ~gate_q;
      end else begin
        gate_cnt_d = gate_cnt_q + 1'b1;
      end
    end
    beep_d = alarm_on_q & tone_q & gate_q;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q      <= '0;
      cfg_en_q   <= '0;
      missed_q   <= '0;
      tone_cnt_q <= '0;
      gate_cnt_q <= '0;
      tone_q     <= 1'b1;
      gate_q     <= 1'b1;
      alarm_on_q <= 1'b0;
      beep_q     <= 1'b0;
      for (int i = 0; i < N_ALARMS; i++) begin
        state_q[i]    <= ST_IDLE;
        cfg_hour_q[i] <= '0;
        cfg_min_q[i]  <= '0;
        tgt_hour_q[i] <= '0;
        tgt_min_q[i]  <= '0;
        timer_q[i]    <= '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
        snz_cnt_q[i]  <= '0;
`endif
      end
    end else begin
      sec_q      <= sec;
      cfg_en_q   <= cfg_en_d;
      missed_q   <= missed_d;
      tone_cnt_q <= tone_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      tone_q     <= tone_d;
      gate_q     <= gate_d;
      alarm_on_q <= alarm_on_d;
      beep_q     <= beep_d;
      for (int i = 0; i < N_ALARMS; i++) begin
        state_q[i]    <= state_d[i];
        cfg_hour_q[i] <= cfg_hour_d[i];
        cfg_min_q[i]  <= cfg_min_d[i];
        tgt_hour_q[i] <= tgt_hour_d[i];
        tgt_min_q[i]  <= tgt_min_d[i];
        timer_q[i]    <= timer_d[i];
`ifdef ALARM_SNOOZE_LIMIT_EN
        snz_cnt_q[i]  <= snz_cnt_d[i];
`endif
      end
    end
  end

  // Output decode
  always_comb begin
    ring_mask = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      ring_mask[i] = (state_q[i] == ST_RINGING);
    end
  end

  assign missed_mask = missed_q;
  assign alarm_on    = alarm_on_q;
  assign beep        = beep_q;

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed self-checking bench for alarm_bank with short
// tone/gate/timeout parameters so ring, snooze, timeout, write, reset and
// snooze-limit behaviour all fit in a few hundred cycles.
module tb_alarm_bank;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [4:0]   hour;
  logic [5:0]   min;
  logic [5:0]   sec;
  logic         wr_en;
  logic [1:0]   wr_idx;
  logic [4:0]   wr_hour;
  logic [5:0]   wr_min;
  logic         wr_enable;
  logic         snooze_pulse;
  logic         dismiss_pulse;
  logic [N-1:0] ring_mask;
  logic [N-1:0] missed_mask;
  logic         alarm_on;
  logic         beep;

  int assertCount = 0;
  int failCount   = 0;

  alarm_bank #(
    .N_ALARMS      (N),
    .SNOOZE_MIN    (5),
    .RING_TIMEOUT_S(3),
    .TONE_HALF_CYC (2),
    .GATE_HALF_CYC (8),
    .MAX_SNOOZE    (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hour         (hour),
    .min          (min),
    .sec          (sec),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_hour      (wr_hour),
    .wr_min       (wr_min),
    .wr_enable    (wr_enable),
    .snooze_pulse (snooze_pulse),
    .dismiss_pulse(dismiss_pulse),
    .ring_mask    (ring_mask),
    .missed_mask  (missed_mask),
    .alarm_on     (alarm_on),
    .beep         (beep)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are read 1 ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setTime(input int h, input int m, input int s);
    hour = 5'(h);
    min  = 6'(m);
    sec  = 6'(s);
    tick();
  endtask

  task automatic writeCh(input int idx, input int h, input int m, input logic en);
    wr_en     = 1'b1;
    wr_idx    = 2'(idx);
    wr_hour   = 5'(h);
    wr_min    = 6'(m);
    wr_enable = en;
    tick();
    wr_en     = 1'b0;
  endtask

  task automatic pressSnooze;
    snooze_pulse = 1'b1;
    tick();
    snooze_pulse = 1'b0;
  endtask

  task automatic pressDismiss;
    dismiss_pulse = 1'b1;
    tick();
    dismiss_pulse = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    assertCount++;
    if ({ring_mask, missed_mask, alarm_on, beep} !== 10'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got %b required %b",
               {ring_mask, missed_mask, alarm_on, beep}, 10'b0);
    end
    rst = 1'b0;
    // Cleared configs are disarmed, so 00:00 must not ring.
    setTime(23, 59, 59);
    setTime(0, 0, 0);
    tick();
    assertCount++;
    if (ring_mask !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL reset_disarmed: got %b required %b", ring_mask, 4'b0000);
    end
  endtask

  task automatic test_ring_and_beep;
    logic expBeep;
    writeCh(0, 7, 30, 1'b1);
    setTime(7, 29, 59);
    assertCount++;
    if (ring_mask !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL ring_early: got %b required %b", ring_mask, 4'b0000);
    end
    setTime(7, 30, 0);
    assertCount++;
    if (ring_mask !== 4'b0001 || alarm_on !== 1'b1 || beep !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ring_start: got ring=%b on=%b beep=%b required ring=0001 on=1 beep=0",
               ring_mask, alarm_on, beep);
    end
    // Tone period 4 cycles, gate 8 on / 8 off, starting the cycle after alarm_on.
    for (int k = 1; k <= 20; k++) begin
      tick();
      expBeep = ((((k - 1) / 2) % 2) == 0) && ((((k - 1) / 8) % 2) == 0);
      assertCount++;
      if (beep !== expBeep) begin
        failCount++;
        $display("[TB] FAIL beep_pattern k=%0d: got %b required %b", k, beep, expBeep);
      end
    end
    pressDismiss();
    tick();
    assertCount++;
    if (ring_mask !== 4'b0000 || alarm_on !== 1'b0 || beep !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL dismiss_ch0: got ring=%b on=%b beep=%b required 0000 0 0",
               ring_mask, alarm_on, beep);
    end
  endtask

  task automatic test_snooze_wrap;
    writeCh(1, 23, 58, 1'b1);
    setTime(23, 57, 59);
    setTime(23, 58, 0);
    assertCount++;
    if (ring_mask !== 4'b0010) begin
      failCount++;
      $display("[TB] FAIL snooze_ring: got %b required %b", ring_mask, 4'b0010);
    end
    hour = 5'd23; min = 6'd58; sec = 6'd10;
    pressSnooze();
    assertCount++;
    if (ring_mask !== 4'b0000 || alarm_on !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL snoozed: got ring=%b on=%b required 0000 0", ring_mask, alarm_on);
    end
    setTime(0, 2, 59);
    assertCount++;
    if (ring_mask !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL snooze_early: got %b required %b", ring_mask, 4'b0000);
    end
    setTime(0, 3, 0);
    assertCount++;
    if (ring_mask !== 4'b0010) begin
      failCount++;
      $display("[TB] FAIL snooze_wrap: got %b required %b", ring_mask, 4'b0010);
    end
    pressDismiss();
  endtask

  task automatic test_timeout_missed;
    writeCh(2, 6, 0, 1'b1);
    setTime(5, 59, 59);
    setTime(6, 0, 0);
    setTime(6, 0, 1);
    setTime(6, 0, 2);
    assertCount++;
    if (ring_mask !== 4'b0100 || missed_mask !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL timeout_early: got ring=%b missed=%b required 0100 0000",
               ring_mask, missed_mask);
    end
    setTime(6, 0, 3);
    assertCount++;
    if (ring_mask !== 4'b0000 || missed_mask !== 4'b0100) begin
      failCount++;
      $display("[TB] FAIL timeout: got ring=%b missed=%b required 0000 0100",
               ring_mask, missed_mask);
    end
    writeCh(2, 6, 0, 1'b1);
    assertCount++;
    if (missed_mask !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL missed_clear: got %b required %b", missed_mask, 4'b0000);
    end
  endtask

  task automatic test_simultaneous;
    writeCh(0, 12, 0, 1'b1);
    writeCh(3, 12, 0, 1'b1);
    setTime(11, 59, 59);
    setTime(12, 0, 0);
    assertCount++;
    if (ring_mask !== 4'b1001 || alarm_on !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL both_ring: got ring=%b on=%b required 1001 1", ring_mask, alarm_on);
    end
    dismiss_pulse = 1'b1;
    snooze_pulse  = 1'b1;
    tick();
    dismiss_pulse = 1'b0;
    snooze_pulse  = 1'b0;
    assertCount++;
    if (ring_mask !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL both_dismiss: got %b required %b", ring_mask, 4'b0000);
    end
    // A snooze would have targeted 12:05; dismiss must win so nothing rings.
    setTime(12, 4, 59);
    setTime(12, 5, 0);
    assertCount++;
    if (ring_mask !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL dismiss_over_snooze: got %b required %b", ring_mask, 4'b0000);
    end
  endtask

  task automatic test_write_dismiss_reset;
    writeCh(0, 12, 6, 1'b1);
    setTime(12, 5, 59);
    setTime(12, 6, 0);
    tick();
    assertCount++;
    if (ring_mask !== 4'b0001 || beep !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL ring_before_write: got ring=%b beep=%b required 0001 1", ring_mask, beep);
    end
    dismiss_pulse = 1'b1;
    writeCh(0, 12, 0, 1'b0);
    dismiss_pulse = 1'b0;
    tick();
    assertCount++;
    if (ring_mask !== 4'b0000 || alarm_on !== 1'b0 || beep !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL write_disarm: got ring=%b on=%b beep=%b required 0000 0 0",
               ring_mask, alarm_on, beep);
    end
    writeCh(0, 12, 8, 1'b1);
    setTime(12, 7, 59);
    setTime(12, 8, 0);
    tick();
    rst = 1'b1;
    tick();
    assertCount++;
    if ({ring_mask, missed_mask, alarm_on, beep} !== 10'b0) begin
      failCount++;
      $display("[TB] FAIL reset_mid_ring: got %b required %b",
               {ring_mask, missed_mask, alarm_on, beep}, 10'b0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_snooze_limit;
    logic [N-1:0] expRing;
    writeCh(1, 1, 0, 1'b1);
    setTime(0, 59, 59);
    setTime(1, 0, 0);
    for (int j = 1; j <= 3; j++) begin
      pressSnooze();
      setTime(1, 5 * j - 1, 59);
      setTime(1, 5 * j, 0);
      assertCount++;
      if (ring_mask !== 4'b0010) begin
        failCount++;
        $display("[TB] FAIL snooze_repeat %0d: got %b required %b", j, ring_mask, 4'b0010);
      end
    end
    pressSnooze();
    setTime(1, 19, 59);
    setTime(1, 20, 0);
`ifdef ALARM_SNOOZE_LIMIT_EN
    expRing = 4'b0000;
`else
    expRing = 4'b0010;
`endif
    assertCount++;
    if (ring_mask !== expRing || missed_mask !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL fourth_snooze: got ring=%b missed=%b required %b 0000",
               ring_mask, missed_mask, expRing);
    end
  endtask

  initial begin
    rst           = 1'b1;
    hour          = '0;
    min           = '0;
    sec           = '0;
    wr_en         = 1'b0;
    wr_idx        = '0;
    wr_hour       = '0;
    wr_min        = '0;
    wr_enable     = 1'b0;
    snooze_pulse  = 1'b0;
    dismiss_pulse = 1'b0;
    test_reset();
    test_ring_and_beep();
    test_snooze_wrap();
    test_timeout_missed();
    test_simultaneous();
    test_write_dismiss_reset();
    test_snooze_limit();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
